mem_stage_lsu: RTL and testbench

MEM_STAGE_LSU -- requirements
Module: mem_stage_lsu

---
 rtl/mem_stage_lsu_if.sv | 20 ++
 rtl/mem_stage_lsu.sv | 172 +++++++++++++++++
 tb/tb_mem_stage_lsu.sv | 241 ++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_stage_lsu_if.sv
// rtl/mem_stage_lsu_if.sv - data-memory request/response bus between the LSU and the memory
interface mem_stage_lsu_if;
    logic        dm_req;
    logic [31:0] dm_addr;
    logic        dm_web;
    logic [31:0] dm_bweb;
    logic [31:0] dm_wdata;
    logic        dm_ready;
    logic [31:0] dm_rdata;

    modport master (
        output dm_req, dm_addr, dm_web, dm_bweb, dm_wdata,
        input  dm_ready, dm_rdata
    );

    modport slave (
        input  dm_req, dm_addr, dm_web, dm_bweb, dm_wdata,
        output dm_ready, dm_rdata
    );
endinterface

// File: rtl/mem_stage_lsu.sv
// rtl/mem_stage_lsu.sv - MEM-stage load/store unit, optional misalignment trap via LSU_MISALIGN_TRAP_EN
module mem_stage_lsu (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [6:0]             M_op,
    input  logic [2:0]             M_funct3,
    input  logic [4:0]             M_rd,
    input  logic                   M_reg_write_enable,
    input  logic                   M_wb_data_sel,
    input  logic                   M_web,
    input  logic [31:0]            M_dm_write_enable,
    input  logic [31:0]            M_alu_out,
    input  logic [31:0]            M_dm_data,
    mem_stage_lsu_if.master        dm,
    output logic                   mem_stall,
    output logic [4:0]             W_rd,
    output logic                   W_reg_write_enable,
    output logic                   W_wb_data_sel,
    output logic [31:0]            W_alu_out,
    output logic [31:0]            W_ld_data,
    output logic                   misalign_err
);
    typedef enum logic {IDLE, BUSY} state_t;

    state_t      state_q, state_d;
    logic        capture, complete, trap;
    logic        is_load, is_store, is_access, misalign;

    logic [31:0] addr_q, wdata_q, bweb_q;
    logic        web_q, load_q, we_q, sel_q;
    logic [2:0]  f3_q;
    logic [4:0]  rd_q;

    logic [4:0]  w_rd_q;
    logic        w_we_q, w_sel_q;
    logic [31:0] w_alu_q, w_ld_q;

    assign is_load   = (M_op == 7'b0000011);
    assign is_store  = (M_op == 7'b0100011);
    assign is_access = is_load | is_store;

`ifdef LSU_MISALIGN_TRAP_EN
    logic misalign_err_q;
    assign misalign = is_access &&
                      (((M_funct3[1:0] == 2'b01) && M_alu_out[0]) ||
                       ((M_funct3[1:0] == 2'b10) && (M_alu_out[1:0] != 2'b00)));
    assign misalign_err = misalign_err_q;

    // One-cycle trap pulse registered alongside the bubbled write-back
    always_ff @(posedge clk or posedge rst) begin
        if (rst) misalign_err_q <= 1'b0;
        else     misalign_err_q <= trap;
    end
`else
    assign misalign     = 1'b0;
    assign misalign_err = 1'b0;
`endif

    // Byte lane picks addr[1:0], half lane picks addr[1]; unknown funct3 returns the word
    function automatic logic [31:0] extract(input logic [2:0] f3, input logic [1:0] a,
                                            input logic [31:0] w);
        logic [7:0]  b;
        logic [15:0] h;
        b = w[{a, 3'b000} +: 8];
        h = a[1] ? w[31:16] : w[15:0];
        case (f3)
            3'd0:    return {{24{b[7]}}, b};
            3'd1:    return {{16{h[15]}}, h};
            3'd4:    return {24'd0, b};
            3'd5:    return {16'd0, h};
            default: return w;
        endcase
    endfunction

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // Next state and stall: capture in IDLE, wait for dm_ready in BUSY
    always_comb begin
        state_d   = state_q;
        mem_stall = 1'b0;
        capture   = 1'b0;
        complete  = 1'b0;
        trap      = 1'b0;
        case (state_q)
            IDLE: begin
                if (is_access) begin
                    if (misalign) begin
                        trap = 1'b1;
                    end else begin
                        capture   = 1'b1;
                        mem_stall = 1'b1;
                        state_d   = BUSY;
                    end
                end
            end
            BUSY: begin
                if (dm.dm_ready) begin
                    complete = 1'b1;
                    state_d  = IDLE;
                end else begin
                    mem_stall = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Access capture; these registers drive the memory bus for the whole BUSY phase
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_q  <= 32'd0;
            wdata_q <= 32'd0;
            bweb_q  <= 32'hFFFF_FFFF;
            web_q   <= 1'b1;
            load_q  <= 1'b0;
            f3_q    <= 3'd0;
            rd_q    <= 5'd0;
            we_q    <= 1'b0;
            sel_q   <= 1'b0;
        end else if (capture) begin
            addr_q  <= M_alu_out;
            wdata_q <= M_dm_data;
            bweb_q  <= M_dm_write_enable;
            web_q   <= M_web;
            load_q  <= is_load;
            f3_q    <= M_funct3;
            rd_q    <= M_rd;
            we_q    <= M_reg_write_enable;
            sel_q   <= M_wb_data_sel;
        end
    end

    // Write-back register: completion, bubble while stalled, or pass-through
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            w_rd_q  <= 5'd0;
            w_we_q  <= 1'b0;
            w_sel_q <= 1'b0;
            w_alu_q <= 32'd0;
            w_ld_q  <= 32'd0;
        end else if (complete) begin
            w_rd_q  <= rd_q;
            w_we_q  <= we_q;
            w_sel_q <= sel_q;
            w_alu_q <= addr_q;
            w_ld_q  <= load_q ? extract(f3_q, addr_q[1:0], dm.dm_rdata) : 32'd0;
        end else if (mem_stall) begin
            w_we_q  <= 1'b0;
        end else begin
            w_rd_q  <= M_rd;
            w_we_q  <= M_reg_write_enable & ~trap;
            w_sel_q <= M_wb_data_sel;
            w_alu_q <= M_alu_out;
        end
    end

    assign dm.dm_req   = (state_q == BUSY);
    assign dm.dm_addr  = addr_q;
    assign dm.dm_wdata = wdata_q;
    assign dm.dm_web   = (state_q == BUSY) ? web_q  : 1'b1;
    assign dm.dm_bweb  = (state_q == BUSY) ? bweb_q : 32'hFFFF_FFFF;

    assign W_rd               = w_rd_q;
    assign W_reg_write_enable = w_we_q;
    assign W_wb_data_sel      = w_sel_q;
    assign W_alu_out          = w_alu_q;
    assign W_ld_data          = w_ld_q;
endmodule

// File: tb/tb_mem_stage_lsu.sv
// tb/tb_mem_stage_lsu.sv - directed bench with retirement-queue model for mem_stage_lsu
module tb_mem_stage_lsu;
    localparam logic [6:0] OP_LD  = 7'b0000011;
    localparam logic [6:0] OP_ST  = 7'b0100011;
    localparam logic [6:0] OP_ADD = 7'b0110011;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [6:0]  M_op = 7'd0;
    logic [2:0]  M_funct3 = 3'd0;
    logic [4:0]  M_rd = 5'd0;
    logic        M_reg_write_enable = 1'b0;
    logic        M_wb_data_sel = 1'b0;
    logic        M_web = 1'b1;
    logic [31:0] M_dm_write_enable = 32'hFFFF_FFFF;
    logic [31:0] M_alu_out = 32'd0;
    logic [31:0] M_dm_data = 32'd0;
    logic        mem_stall;
    logic [4:0]  W_rd;
    logic        W_reg_write_enable;
    logic        W_wb_data_sel;
    logic [31:0] W_alu_out;
    logic [31:0] W_ld_data;
    logic        misalign_err;

    mem_stage_lsu_if dmif ();

    mem_stage_lsu dut (
        .clk(clk), .rst(rst),
        .M_op(M_op), .M_funct3(M_funct3), .M_rd(M_rd),
        .M_reg_write_enable(M_reg_write_enable), .M_wb_data_sel(M_wb_data_sel),
        .M_web(M_web), .M_dm_write_enable(M_dm_write_enable),
        .M_alu_out(M_alu_out), .M_dm_data(M_dm_data),
        .dm(dmif.master),
        .mem_stall(mem_stall), .W_rd(W_rd), .W_reg_write_enable(W_reg_write_enable),
        .W_wb_data_sel(W_wb_data_sel), .W_alu_out(W_alu_out), .W_ld_data(W_ld_data),
        .misalign_err(misalign_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [4:0]  rd;
        logic        we;
        logic        sel;
        logic [31:0] alu;
        logic [31:0] ld;
        logic        chk_ctl;
        logic        chk_ld;
        logic        trap;
    } exp_t;

    exp_t q[$];
    int   n_vec = 0;
    int   n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] ld_model(input logic [2:0] f3, input logic [31:0] a,
                                             input logic [31:0] w);
        logic [31:0] sb, sh;
        sb = w >> (8 * a[1:0]);
        sh = w >> (16 * a[1]);
        case (f3)
            3'd0:    return 32'($signed(sb[7:0]));
            3'd1:    return 32'($signed(sh[15:0]));
            3'd4:    return {24'd0, sb[7:0]};
            3'd5:    return {16'd0, sh[15:0]};
            default: return w;
        endcase
    endfunction

    // Every clock edge where mem_stall was low retires exactly one instruction
    logic prev_ok = 1'b0;
    logic prev_stall = 1'b0;
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            prev_ok = 1'b0;
        end else begin
            if (prev_ok) begin
                if (!prev_stall) begin
                    if (q.size() == 0) begin
                        n_vec++; n_err++;
                        $display("FAIL wb_extra: got retirement expected none");
                    end else begin
                        e = q.pop_front();
                        chk("wb_we", {31'd0, W_reg_write_enable}, {31'd0, e.we});
                        chk("wb_misalign", {31'd0, misalign_err}, {31'd0, e.trap});
                        if (e.chk_ctl) begin
                            chk("wb_rd", {27'd0, W_rd}, {27'd0, e.rd});
                            chk("wb_sel", {31'd0, W_wb_data_sel}, {31'd0, e.sel});
                            chk("wb_alu", W_alu_out, e.alu);
                        end
                        if (e.chk_ld) chk("wb_ld", W_ld_data, e.ld);
                    end
                end else begin
                    chk("bubble_we", {31'd0, W_reg_write_enable}, 32'd0);
                    chk("bubble_misalign", {31'd0, misalign_err}, 32'd0);
                end
            end
            if (!dmif.dm_req) begin
                chk("idle_web", {31'd0, dmif.dm_web}, 32'd1);
                chk("idle_bweb", dmif.dm_bweb, 32'hFFFF_FFFF);
            end
            prev_stall = mem_stall;
            prev_ok    = 1'b1;
        end
    end

    // Called just after a rising edge; presents one instruction and plays the memory side
    task automatic issue(input logic [6:0] op, input logic [2:0] f3, input logic [4:0] rd,
                         input logic we, input logic sel, input logic web,
                         input logic [31:0] mask, input logic [31:0] a, input logic [31:0] d,
                         input int lat, input logic [31:0] rdata);
        exp_t e;
        logic is_ld, is_mem, trap;
        is_ld  = (op == OP_LD);
        is_mem = is_ld || (op == OP_ST);
`ifdef LSU_MISALIGN_TRAP_EN
        trap = is_mem && (((f3[1:0] == 2'b01) && a[0]) || ((f3[1:0] == 2'b10) && (a[1:0] != 2'b00)));
`else
        trap = 1'b0;
`endif
        M_op = op; M_funct3 = f3; M_rd = rd; M_reg_write_enable = we; M_wb_data_sel = sel;
        M_web = web; M_dm_write_enable = mask; M_alu_out = a; M_dm_data = d;
        e.rd = rd; e.sel = sel; e.alu = a; e.trap = trap;
        e.we = we && !trap;
        e.chk_ctl = !trap;
        e.chk_ld  = is_mem && !trap;
        e.ld = is_ld ? ld_model(f3, a, rdata) : 32'd0;
        q.push_back(e);
        if (is_mem && !trap) begin
            @(negedge clk);
            chk("cap_stall", {31'd0, mem_stall}, 32'd1);
            chk("cap_req", {31'd0, dmif.dm_req}, 32'd0);
            @(posedge clk); #1;
            for (int k = 0; k <= lat; k++) begin
                dmif.dm_ready = (k == lat);
                dmif.dm_rdata = rdata;
                @(negedge clk);
                chk("busy_req", {31'd0, dmif.dm_req}, 32'd1);
                chk("busy_addr", dmif.dm_addr, a);
                chk("busy_wdata", dmif.dm_wdata, d);
                chk("busy_web", {31'd0, dmif.dm_web}, {31'd0, web});
                chk("busy_bweb", dmif.dm_bweb, mask);
                chk("busy_stall", {31'd0, mem_stall}, {31'd0, (k != lat)});
                @(posedge clk); #1;
            end
            dmif.dm_ready = 1'b0;
            dmif.dm_rdata = 32'd0;
        end else begin
            @(negedge clk);
            chk("pass_stall", {31'd0, mem_stall}, 32'd0);
            chk("pass_req", {31'd0, dmif.dm_req}, 32'd0);
            @(posedge clk); #1;
        end
    endtask

    task automatic nop();
        issue(OP_ADD, 3'd0, 5'd0, 1'b0, 1'b0, 1'b1, 32'hFFFF_FFFF, 32'd0, 32'd0, 0, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        dmif.dm_ready = 1'b0;
        dmif.dm_rdata = 32'd0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_req", {31'd0, dmif.dm_req}, 32'd0);
        chk("rst_web", {31'd0, dmif.dm_web}, 32'd1);
        chk("rst_bweb", dmif.dm_bweb, 32'hFFFF_FFFF);
        chk("rst_addr", dmif.dm_addr, 32'd0);
        chk("rst_wdata", dmif.dm_wdata, 32'd0);
        chk("rst_wwe", {31'd0, W_reg_write_enable}, 32'd0);
        chk("rst_wrd", {27'd0, W_rd}, 32'd0);
        chk("rst_walu", W_alu_out, 32'd0);
        chk("rst_wld", W_ld_data, 32'd0);
        chk("rst_misalign", {31'd0, misalign_err}, 32'd0);

        chk("pin_lw", ld_model(3'd2, 32'h100, 32'h8899AABB), 32'h8899AABB);
        chk("pin_lb", ld_model(3'd0, 32'h103, 32'h80112233), 32'hFFFFFF80);
        chk("pin_lbu", ld_model(3'd4, 32'h103, 32'h80112233), 32'h00000080);
        chk("pin_lhu", ld_model(3'd5, 32'h102, 32'h80112233), 32'h00008011);

        @(posedge clk); #1;
        rst = 1'b0;

        // ADD, LW, ADD back to back
        issue(OP_ADD, 3'd0, 5'd1, 1'b1, 1'b0, 1'b1, 32'hFFFF_FFFF, 32'h11, 32'd0, 0, 32'd0);
        issue(OP_LD, 3'd2, 5'd2, 1'b1, 1'b1, 1'b1, 32'hFFFF_FFFF, 32'h100, 32'd0, 0, 32'h8899AABB);
        issue(OP_ADD, 3'd0, 5'd3, 1'b1, 1'b0, 1'b1, 32'hFFFF_FFFF, 32'h33, 32'd0, 0, 32'd0);
        // Sub-word loads
        issue(OP_LD, 3'd0, 5'd4, 1'b1, 1'b1, 1'b1, 32'hFFFF_FFFF, 32'h103, 32'd0, 1, 32'h80112233);
        issue(OP_LD, 3'd4, 5'd5, 1'b1, 1'b1, 1'b1, 32'hFFFF_FFFF, 32'h103, 32'd0, 0, 32'h80112233);
        issue(OP_LD, 3'd5, 5'd6, 1'b1, 1'b1, 1'b1, 32'hFFFF_FFFF, 32'h102, 32'd0, 0, 32'h80112233);
        issue(OP_LD, 3'd1, 5'd7, 1'b1, 1'b1, 1'b1, 32'hFFFF_FFFF, 32'h102, 32'd0, 2, 32'h80112233);
        issue(OP_LD, 3'd3, 5'd8, 1'b1, 1'b1, 1'b1, 32'hFFFF_FFFF, 32'h104, 32'd0, 0, 32'hCAFEF00D);
        // Stores: long wait word store, then a masked byte store
        issue(OP_ST, 3'd2, 5'd0, 1'b0, 1'b0, 1'b0, 32'h0000_0000, 32'h200, 32'hDEADBEEF, 3, 32'd0);
        issue(OP_ST, 3'd0, 5'd0, 1'b0, 1'b0, 1'b0, 32'hFFFF_00FF, 32'h201, 32'h0000AB00, 0, 32'd0);
        // Misaligned word and half accesses
        issue(OP_LD, 3'd2, 5'd9, 1'b1, 1'b1, 1'b1, 32'hFFFF_FFFF, 32'h102, 32'd0, 1, 32'h01020304);
        issue(OP_ADD, 3'd0, 5'd10, 1'b1, 1'b0, 1'b1, 32'hFFFF_FFFF, 32'hAA, 32'd0, 0, 32'd0);
        issue(OP_LD, 3'd1, 5'd11, 1'b1, 1'b1, 1'b1, 32'hFFFF_FFFF, 32'h101, 32'd0, 0, 32'hA1B2C3D4);
        nop();

        // Reset in the second BUSY cycle of a load abandons it
        M_op = OP_LD; M_funct3 = 3'd2; M_rd = 5'd12; M_reg_write_enable = 1'b1;
        M_wb_data_sel = 1'b1; M_web = 1'b1; M_dm_write_enable = 32'hFFFF_FFFF;
        M_alu_out = 32'h300; M_dm_data = 32'd0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1;
        M_op = 7'd0; M_reg_write_enable = 1'b0; M_rd = 5'd0; M_alu_out = 32'd0;
        #1;
        chk("abort_req", {31'd0, dmif.dm_req}, 32'd0);
        chk("abort_wwe", {31'd0, W_reg_write_enable}, 32'd0);
        chk("abort_web", {31'd0, dmif.dm_web}, 32'd1);
        @(posedge clk); #1;
        rst = 1'b0;
        issue(OP_LD, 3'd2, 5'd13, 1'b1, 1'b1, 1'b1, 32'hFFFF_FFFF, 32'h304, 32'd0, 2, 32'h12345678);
        issue(OP_ADD, 3'd0, 5'd14, 1'b1, 1'b0, 1'b1, 32'hFFFF_FFFF, 32'h77, 32'd0, 0, 32'd0);
        nop();
        nop();
        chk("queue_drained", q.size(), 32'd1);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
